// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared CP0 definitions for the exception sequencer.
// Register numbers, STATUS/CAUSE fields, ExcCodes, vectors, FSM states.
package exc_ctrl_pkg;

   localparam logic [31:0] VEC_NORMAL = 32'h0000_3000;
   localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;
   localparam int          N_IRQ      = 6;

   localparam logic [4:0] CP0_STATUS    = 5'd12;
   localparam logic [4:0] CP0_CAUSE     = 5'd13;
   localparam logic [4:0] CP0_EPC       = 5'd14;
   localparam logic [4:0] CP0_ERROR_EPC = 5'd30;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_ERL = 2;
   localparam int ST_BEV = 22;
   localparam int CA_BD  = 31;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_CAUSE,
      S_W_EPC,
      S_W_STATUS,
      S_REDIRECT,
      S_E_STATUS,
      S_E_REDIRECT
   } state_t;

   // {BD, 0, IP[7:2], IP[1:0]=0, 0, ExcCode, 00}
   function automatic logic [31:0] cause_word(
      input logic             bd,
      input logic [N_IRQ-1:0] ip,
      input logic [4:0]       code
   );
      return {bd, 15'b0, ip, 2'b0, 1'b0, code, 2'b0};
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: CP0 single write port (we/num/sel/wdata).
// master = exception sequencer, slave = CP0 register file.
interface exc_ctrl_if;
   logic        we;
   logic [4:0]  num;
   logic [2:0]  sel;
   logic [31:0] wdata;

   modport master (output we, num, sel, wdata);
   modport slave  (input  we, num, sel, wdata);
endinterface

// File: rtl/exc_ctrl_prio.sv
// exc_prio: combinational priority encoder for exception requests.
// In: flags, int_pend, eret, valid. Out: take, is_eret, code.
import exc_ctrl_pkg::*;

module exc_prio (
   input  logic       valid,
   input  logic       exc_ri,
   input  logic       exc_ov,
   input  logic       exc_sys,
   input  logic       exc_bp,
   input  logic       int_pend,
   input  logic       eret,
   output logic       take,
   output logic       is_eret,
   output logic [4:0] code
);

   // Flags overlap, so this is a true priority chain.
   always_comb begin
      take    = 1'b0;
      is_eret = 1'b0;
      code    = EXC_INT;
      if (valid) begin
         if (exc_ri) begin
            take = 1'b1;
            code = EXC_RI;
         end else if (exc_ov) begin
            take = 1'b1;
            code = EXC_OV;
         end else if (exc_sys) begin
            take = 1'b1;
            code = EXC_SYS;
         end else if (exc_bp) begin
            take = 1'b1;
            code = EXC_BP;
         end else if (int_pend) begin
            take = 1'b1;
            code = EXC_INT;
         end else if (eret) begin
            take    = 1'b1;
            is_eret = 1'b1;
         end
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0 exception/interrupt/ERET sequencer.
// Ports: MEM-stage flags + CP0 state in; CP0 write bus, busy/flush/redirect out.
import exc_ctrl_pkg::*;

module exc_ctrl (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             exc_ri,
   input  logic             exc_ov,
   input  logic             exc_sys,
   input  logic             exc_bp,
   input  logic             eret,
   input  logic [31:0]      inst_pc,
   input  logic             inst_in_ds,
   input  logic             inst_valid,
   input  logic [N_IRQ-1:0] irq,
   input  logic [31:0]      cp0_status,
   input  logic [31:0]      cp0_epc,
   input  logic [31:0]      cp0_error_epc,
   exc_ctrl_if.master       cp0,
   output logic             busy,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc
);

   state_t      state;
   logic [31:0] pc_q;
   logic        ds_q;
   logic [31:0] status_q;
   logic [31:0] epc_q;
   logic [31:0] eepc_q;

   logic        int_pend;
   logic        take;
   logic        is_eret;
   logic [4:0]  code;

   assign int_pend = (|(irq & cp0_status[15:10]))
                   & cp0_status[ST_IE]
                   & ~cp0_status[ST_EXL]
                   & ~cp0_status[ST_ERL];

   exc_prio u_prio (
      .valid    (inst_valid),
      .exc_ri   (exc_ri),
      .exc_ov   (exc_ov),
      .exc_sys  (exc_sys),
      .exc_bp   (exc_bp),
      .int_pend (int_pend),
      .eret     (eret),
      .take     (take),
      .is_eret  (is_eret),
      .code     (code)
   );

   assign cp0.sel = 3'd0;

   // Outputs are registered on entry to each state, so the
   // write/redirect for a state is visible while in that state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         pc_q           <= '0;
         ds_q           <= 1'b0;
         status_q       <= '0;
         epc_q          <= '0;
         eepc_q         <= '0;
         busy           <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         cp0.we         <= 1'b0;
         cp0.num        <= '0;
         cp0.wdata      <= '0;
      end else begin
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         cp0.we         <= 1'b0;
         cp0.num        <= '0;
         cp0.wdata      <= '0;
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  pc_q     <= inst_pc;
                  ds_q     <= inst_in_ds;
                  status_q <= cp0_status;
                  epc_q    <= cp0_epc;
                  eepc_q   <= cp0_error_epc;
                  busy     <= 1'b1;
                  flush    <= 1'b1;
                  cp0.we   <= 1'b1;
                  if (is_eret) begin
                     state   <= S_E_STATUS;
                     cp0.num <= CP0_STATUS;
                     if (cp0_status[ST_ERL])
                        cp0.wdata <= cp0_status & ~32'h4;
                     else
                        cp0.wdata <= cp0_status & ~32'h2;
                  end else begin
                     state     <= S_W_CAUSE;
                     cp0.num   <= CP0_CAUSE;
                     cp0.wdata <= cause_word(inst_in_ds,
                                             irq, code);
                  end
               end
            end
            S_W_CAUSE: begin
               cp0.we <= 1'b1;
               // Nested exception keeps the original EPC.
               if (status_q[ST_EXL]) begin
                  state     <= S_W_STATUS;
                  cp0.num   <= CP0_STATUS;
                  cp0.wdata <= status_q | 32'h2;
               end else begin
                  state     <= S_W_EPC;
                  cp0.num   <= CP0_EPC;
                  cp0.wdata <= ds_q ? pc_q - 32'd4 : pc_q;
               end
            end
            S_W_EPC: begin
               state     <= S_W_STATUS;
               cp0.we    <= 1'b1;
               cp0.num   <= CP0_STATUS;
               cp0.wdata <= status_q | 32'h2;
            end
            S_W_STATUS: begin
               state          <= S_REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= status_q[ST_BEV] ?
                                 VEC_BOOT : VEC_NORMAL;
            end
            S_E_STATUS: begin
               state          <= S_E_REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= status_q[ST_ERL] ?
                                 eepc_q : epc_q;
            end
            S_REDIRECT, S_E_REDIRECT: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl.
// Driver pushes expected output cycles; monitor pops on activity.
import exc_ctrl_pkg::*;

module tb_exc_ctrl;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             exc_ri, exc_ov, exc_sys, exc_bp, eret;
   logic [31:0]      inst_pc;
   logic             inst_in_ds, inst_valid;
   logic [N_IRQ-1:0] irq;
   logic [31:0]      cp0_status, cp0_epc, cp0_error_epc;
   logic             busy, flush, redirect_valid;
   logic [31:0]      redirect_pc;

   exc_ctrl_if cp0 ();

   exc_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .exc_ri        (exc_ri),
      .exc_ov        (exc_ov),
      .exc_sys       (exc_sys),
      .exc_bp        (exc_bp),
      .eret          (eret),
      .inst_pc       (inst_pc),
      .inst_in_ds    (inst_in_ds),
      .inst_valid    (inst_valid),
      .irq           (irq),
      .cp0_status    (cp0_status),
      .cp0_epc       (cp0_epc),
      .cp0_error_epc (cp0_error_epc),
      .cp0           (cp0.master),
      .busy          (busy),
      .flush         (flush),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic        flush;
      logic        we;
      logic [4:0]  num;
      logic [31:0] wdata;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic push_w(input logic fl, input logic [4:0] n,
                         input logic [31:0] d);
      exp_t e;
      e = '{busy:1'b1, flush:fl, we:1'b1, num:n, wdata:d,
            rv:1'b0, rpc:32'h0};
      q.push_back(e);
   endtask

   task automatic push_r(input logic [31:0] pc);
      exp_t e;
      e = '{busy:1'b1, flush:1'b0, we:1'b0, num:5'd0,
            wdata:32'h0, rv:1'b1, rpc:pc};
      q.push_back(e);
   endtask

   task automatic clear_in();
      exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
      eret = 0; inst_pc = 0; inst_in_ds = 0;
      inst_valid = 0; irq = 0; cp0_status = 0;
      cp0_epc = 0; cp0_error_epc = 0;
   endtask

   // flags = {ri, ov, sys, bp, eret}
   task automatic issue(input logic [4:0] fl,
                        input logic [31:0] pc,
                        input logic ds, input logic v,
                        input logic [N_IRQ-1:0] ir,
                        input logic [31:0] st,
                        input logic [31:0] ep,
                        input logic [31:0] eep);
      {exc_ri, exc_ov, exc_sys, exc_bp, eret} = fl;
      inst_pc = pc; inst_in_ds = ds; inst_valid = v;
      irq = ir; cp0_status = st;
      cp0_epc = ep; cp0_error_epc = eep;
      @(posedge clk); #1;
      clear_in();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain %s: pending=%0d required=0",
                  name, q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic exc_seq(input logic [31:0] cause,
                          input logic exl,
                          input logic [31:0] epc,
                          input logic [31:0] st,
                          input logic [31:0] vec);
      push_w(1'b1, 5'd13, cause);
      if (!exl) push_w(1'b0, 5'd14, epc);
      push_w(1'b0, 5'd12, st);
      push_r(vec);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (busy || flush || cp0.we || redirect_valid ||
          cp0.num != 0 || cp0.wdata != 0 ||
          redirect_pc != 0 || cp0.sel != 0) begin
         errors++;
         $display("FAIL %s: busy=%0b flush=%0b we=%0b num=%0d wd=%h rv=%0b rpc=%h required all zero",
                  name, busy, flush, cp0.we, cp0.num,
                  cp0.wdata, redirect_valid, redirect_pc);
      end
   endtask

   always @(negedge clk) begin
      if (busy || flush || cp0.we || redirect_valid) begin
         exp_t a, e;
         a = '{busy:busy, flush:flush, we:cp0.we,
               num:cp0.num, wdata:cp0.wdata,
               rv:redirect_valid, rpc:redirect_pc};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: got b=%0b f=%0b we=%0b num=%0d wd=%h rv=%0b rpc=%h required idle",
                     a.busy, a.flush, a.we, a.num, a.wdata,
                     a.rv, a.rpc);
         end else begin
            e = q.pop_front();
            if (a != e || cp0.sel != 3'd0) begin
               errors++;
               $display("FAIL cycle: got b=%0b f=%0b we=%0b num=%0d wd=%h rv=%0b rpc=%h required b=%0b f=%0b we=%0b num=%0d wd=%h rv=%0b rpc=%h",
                        a.busy, a.flush, a.we, a.num, a.wdata,
                        a.rv, a.rpc, e.busy, e.flush, e.we,
                        e.num, e.wdata, e.rv, e.rpc);
            end
         end
      end
   end

   initial begin
      clear_in();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1;
      @(posedge clk); #1;

      // syscall, no delay slot
      exc_seq(32'h0000_0020, 0, 32'h100, 32'h2, 32'h3000);
      issue(5'b00100, 32'h100, 0, 1, 0, 32'h0, 0, 0);
      drain("sys");

      // RI in delay slot beats Ov and Bp
      exc_seq(32'h8000_0028, 0, 32'h1FC, 32'h2, 32'h3000);
      issue(5'b11010, 32'h200, 1, 1, 0, 32'h0, 0, 0);
      drain("ri");

      // masked by EXL: no interrupt
      issue(5'b00000, 32'h300, 0, 1, 6'h01, 32'h403, 0, 0);
      issue(5'b00000, 32'h300, 0, 1, 6'h01, 32'h403, 0, 0);
      drain("int_exl");

      // overflow with EXL=1: no EPC write
      exc_seq(32'h0000_0430, 1, 32'h0, 32'h403, 32'h3000);
      issue(5'b01000, 32'h300, 0, 1, 6'h01, 32'h403, 0, 0);
      drain("ov_exl");

      // ERET with ERL
      push_w(1'b1, 5'd12, 32'h0);
      push_r(32'h500);
      issue(5'b00001, 32'h400, 0, 1, 0, 32'h4,
            32'h600, 32'h500);
      drain("eret_erl");

      // ERET with EXL
      push_w(1'b1, 5'd12, 32'h0);
      push_r(32'h600);
      issue(5'b00001, 32'h400, 0, 1, 0, 32'h2,
            32'h600, 32'h500);
      drain("eret_exl");

      // break at pc 0 in delay slot wraps EPC
      exc_seq(32'h8000_0024, 0, 32'hFFFF_FFFC, 32'h2, 32'h3000);
      issue(5'b00010, 32'h0, 1, 1, 0, 32'h0, 0, 0);
      drain("bp_wrap");

      // syscall + ERET, BEV=1
      exc_seq(32'h0000_0020, 0, 32'h400,
              32'h0040_0002, 32'hBFC0_0380);
      issue(5'b00101, 32'h400, 0, 1, 0, 32'h0040_0000,
            32'h600, 0);
      drain("sys_eret_bev");

      // enabled interrupt on irq[1]
      exc_seq(32'h0000_0800, 0, 32'h500, 32'h803, 32'h3000);
      issue(5'b00000, 32'h500, 0, 1, 6'h02, 32'h801, 0, 0);
      drain("int");

      // bubble: nothing accepted
      issue(5'b00100, 32'h600, 0, 0, 6'h3F, 32'hFC01, 0, 0);
      drain("bubble");

      // reset during W_EPC
      push_w(1'b1, 5'd13, 32'h0000_0020);
      push_w(1'b0, 5'd14, 32'h700);
      issue(5'b00100, 32'h700, 0, 1, 0, 32'h0, 0, 0);
      @(posedge clk); #1;
      rst_n = 0;
      @(posedge clk); #1;
      check_idle("mid_reset");
      rst_n = 1;
      drain("mid_reset");

      // normal after reset
      exc_seq(32'h0000_0020, 0, 32'h104, 32'h2, 32'h3000);
      issue(5'b00100, 32'h104, 0, 1, 0, 32'h0, 0, 0);
      drain("sys_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for coprocessor 0. It arbitrates synchronous exceptions (RI, Ov, Syscall, Break), hardware interrupts and ERET from the pipeline.
- It drives CP0's single write port, one register write per cycle, to perform exception entry (CAUSE, EPC, STATUS) and return (STATUS).
- It then issues a one-cycle PC redirect.
- It sits between the MEM-stage exception collection logic and the CP0 register file, and owns the pipeline stall/flush for exception handling.

Parameters:
- VEC_NORMAL, 32'h0000_3000, exception vector when STATUS.BEV=0
- VEC_BOOT, 32'hBFC0_0380, exception vector when STATUS.BEV=1
- N_IRQ, 6, hardware interrupt lines, mapped to CAUSE.IP[7:2] / STATUS.IM[7:2]

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- exc_ri  in  1  reserved-instruction flag, MEM stage
- exc_ov  in  1  arithmetic overflow flag
- exc_sys  in  1  syscall flag
- exc_bp  in  1  break flag
- eret  in  1  ERET in MEM stage
- inst_pc  in  32  PC of MEM-stage instruction
- inst_in_ds  in  1  MEM-stage instruction is in a branch delay slot
- inst_valid  in  1  MEM stage holds a real (non-bubble) instruction
- irq  in  N_IRQ  level-sensitive interrupt lines
- cp0_status  in  32  current STATUS
- cp0_epc  in  32  current EPC
- cp0_error_epc  in  32  current ERROR_EPC
- cp0_we  out  1  CP0 write strobe
- cp0_num  out  5  CP0 register number
- cp0_sel  out  3  CP0 select (always 0)
- cp0_wdata  out  32  CP0 write data
- busy  out  1  stall IF..MEM
- flush  out  1  one-cycle kill of IF..MEM contents
- redirect_valid  out  1  one-cycle PC load
- redirect_pc  out  32  target PC

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; all outputs are 0; captured registers are cleared.
  - Reset mid-sequence abandons any remaining CP0 writes.
- Interrupt pending: int_pend = |(irq & cp0_status[15:10]) & cp0_status[0] & ~cp0_status[1] & ~cp0_status[2].
- Priority, evaluated only in IDLE with inst_valid=1: RI(10) > Ov(12) > Sys(8) > Bp(9) > Int(0) > ERET. Lower-priority requests in the same cycle are dropped.
- The pipeline holds its requests while busy; requests are ignored outside IDLE.
- Accept cycle (T0, IDLE):
  - Capture code, inst_pc, inst_in_ds, irq, cp0_status, cp0_epc, cp0_error_epc.
  - On acceptance: busy=1 and flush=1 registered, visible T1.
- Exception states:
  - W_CAUSE (T1): write reg 13 = {BD=in_ds, 15'b0, IP[7:2]=irq_cap, 2'b0, 1'b0, code[4:0], 2'b0}.
  - W_EPC (T2): write reg 14 = in_ds ? pc-4 : pc. Skipped (state goes direct to W_STATUS) if captured EXL=1; no EPC overwrite for nested exceptions.
  - W_STATUS (T3): write reg 12 = status_cap with bit1 (EXL) set.
  - REDIRECT (T4): redirect_valid=1, redirect_pc = BEV ? VEC_BOOT : VEC_NORMAL. Next state IDLE.
  - busy is high T1..T4; flush is high at T1 only.
  - Total latency is 4 cycles, or 3 if EXL was already set.
- ERET states:
  - E_STATUS (T1): if ERL, write STATUS with bit2 cleared; else write STATUS with bit1 cleared.
  - E_REDIRECT (T2): redirect_pc = ERL ? error_epc_cap : epc_cap. Next state IDLE.
  - flush=1 at T1; busy high T1..T2.
- cp0_we is high for exactly one cycle per write state; cp0_num/cp0_wdata are valid only when cp0_we=1 and are 0 otherwise.
- PC arithmetic is 32-bit modulo: pc 0 in a delay slot yields EPC 32'hFFFF_FFFC.
- ERET together with any exception flag in the same cycle: the exception is taken, ERET is dropped.
- inst_valid=0: nothing is accepted, including interrupts.

Decomposition:
- Shared header cp0_defs.vh (alongside common.v):
  - CP0 register numbers (STATUS 12, CAUSE 13, EPC 14, ERROR_EPC 30)
  - STATUS bit indices (IE 0, EXL 1, ERL 2, IM 15:8, BEV 22)
  - CAUSE fields (BD 31, IP 15:8, EXC 6:2)
  - ExcCode constants
  - FSM state encodings
- One sub-module, exc_prio: combinational priority encoder from flags + int_pend + eret to {take, is_eret, code}.

Test Plan:
- Syscall at pc 32'h0000_0100, no delay slot, STATUS=0:
  - T1 CAUSE=32'h0000_0020; T2 EPC=32'h100; T3 STATUS=32'h2; T4 redirect 32'h0000_3000.
  - busy high for 4 cycles.
- RI in delay slot at pc 32'h200, with exc_ov and exc_bp also asserted:
  - code=10; CAUSE=32'h8000_0028; EPC=32'h1FC.
  - Ov and Bp are dropped.
- STATUS=32'h0000_0403 (EXL=1, IE=1, IM2=1), irq[0]=1: no interrupt is taken.
- Then an overflow with STATUS EXL=1:
  - writes occur only for regs 13 and 12; no EPC write.
  - redirect occurs at T3.
- ERET with STATUS=32'h4, error_epc=32'h500, epc=32'h600:
  - T1 STATUS write 32'h0; T2 redirect 32'h500.
- rst_n low during W_EPC:
  - next cycle all outputs are 0 and state is IDLE; no W_STATUS write occurs.
  - A later syscall sequences normally.
